// File: rtl/ifu_line_fetcher.sv
// Instruction-fetch line requester: owns the sequential fetch PC, issues 64-byte line reads
// to the memory arbiter and hands returned lines to the ibuffer, discarding redirect-stale lines.
module ifu_line_fetcher #(
  parameter int                 ADDR_W   = 64,
  parameter int                 LINE_W   = 512,
  parameter logic [ADDR_W-1:0]  RESET_PC = 'h8000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_resp_valid,
  input  logic [LINE_W-1:0] mem_resp_data,
  output logic              line_valid,
  output logic [LINE_W-1:0] line_data,
  output logic [3:0]        line_offset,
  output logic              busy
);
  localparam int                LB         = $clog2(LINE_W / 8);
  localparam logic [ADDR_W-1:0] LINE_BYTES = ADDR_W'(LINE_W / 8);
  localparam logic [ADDR_W-1:0] LINE_MASK  = ~(LINE_BYTES - 1'b1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d, addr_q;
  logic [3:0]          off_q, off_d, loff_q;
  logic                pend_q, pend_d, stale_q, stale_d, boot_q;
  logic                lv_q, deliver, accept, load_addr;
  logic [LINE_W-1:0]   data_q;

  assign accept        = (state_q == REQ) && mem_req_ready;
  assign mem_req_valid = (state_q == REQ);
  assign mem_req_addr  = addr_q;
  assign line_valid    = lv_q;
  assign line_data     = data_q;
  assign line_offset   = loff_q;
  assign busy          = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    off_d   = off_q;
    pend_d  = pend_q;
    stale_d = stale_q;
    deliver = 1'b0;
    case (state_q)
      IDLE: if (boot_q || fetch_req) state_d = REQ;
      REQ: begin
        if (fetch_req) pend_d = 1'b1;
        if (accept) begin
          state_d = stale_q ? DROP : WAIT;
          stale_d = 1'b0;
        end
      end
      WAIT: begin
        if (fetch_req) pend_d = 1'b1;
        if (mem_resp_valid) begin
          deliver = 1'b1;
          pc_d    = pc_q + LINE_BYTES;
          off_d   = 4'd0;
          state_d = (pend_q || fetch_req) ? REQ : IDLE;
          pend_d  = 1'b0;
        end
      end
      DROP: begin
        if (fetch_req) pend_d = 1'b1;
        if (mem_resp_valid) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
    // Redirect overrides everything above; a request already on the wire keeps its old
    // address and its response is thrown away in DROP.
    if (redirect_valid) begin
      pc_d    = redirect_pc & LINE_MASK;
      off_d   = 4'(redirect_pc[LB-1:2]);
      pend_d  = 1'b0;
      deliver = 1'b0;
      case (state_q)
        IDLE: state_d = REQ;
        REQ: begin
          if (accept) begin
            state_d = DROP;
            stale_d = 1'b0;
          end else begin
            stale_d = 1'b1;
          end
        end
        WAIT:    state_d = mem_resp_valid ? REQ : DROP;
        DROP:    state_d = mem_resp_valid ? REQ : DROP;
        default: state_d = REQ;
      endcase
    end
  end

  assign load_addr = (state_d == REQ) && (state_q != REQ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      boot_q  <= 1'b1;
      pc_q    <= RESET_PC & LINE_MASK;
      off_q   <= 4'(RESET_PC[LB-1:2]);
      pend_q  <= 1'b0;
      stale_q <= 1'b0;
      addr_q  <= '0;
      lv_q    <= 1'b0;
      data_q  <= '0;
      loff_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      boot_q  <= 1'b0;
      pc_q    <= pc_d;
      off_q   <= off_d;
      pend_q  <= pend_d;
      stale_q <= stale_d;
      lv_q    <= deliver;
      if (load_addr) addr_q <= pc_d;
      if (deliver) begin
        data_q <= mem_resp_data;
        loff_q <= off_q;
      end
    end
  end
endmodule

// File: tb/tb_ifu_line_fetcher.sv
// Directed bench for ifu_line_fetcher: table of fetch/redirect transactions plus
// hand-written sequences for stale-request, simultaneous-event and reset corners.
module tb_ifu_line_fetcher;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         fetch_req = 1'b0;
  logic         redirect_valid = 1'b0;
  logic [63:0]  redirect_pc = '0;
  logic         mem_req_valid;
  logic         mem_req_ready = 1'b0;
  logic [63:0]  mem_req_addr;
  logic         mem_resp_valid = 1'b0;
  logic [511:0] mem_resp_data = '0;
  logic         line_valid;
  logic [511:0] line_data;
  logic [3:0]   line_offset;
  logic         busy;

  ifu_line_fetcher dut (
    .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .line_valid(line_valid), .line_data(line_data), .line_offset(line_offset), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int n_lines = 0;
  int n_back2back = 0;
  logic lv_prev = 1'b0;

  always @(negedge clk) begin
    if (line_valid) n_lines <= n_lines + 1;
    if (line_valid && lv_prev) n_back2back <= n_back2back + 1;
    lv_prev <= line_valid;
  end

  typedef struct {
    bit          redir;
    logic [63:0] rpc;
    int          dly;
    int          lat;
    logic [63:0] exp_addr;
    logic [3:0]  exp_off;
  } vec_t;
  vec_t vt[7];

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [511:0] mk(input int s);
    logic [511:0] r;
    for (int j = 0; j < 16; j++) r[j*32 +: 32] = {16'(s), 16'(j)} ^ 32'h5A5A_0000;
    return r;
  endfunction

  task automatic pulse_fetch();
    fetch_req = 1'b1;
    @(negedge clk);
    fetch_req = 1'b0;
  endtask

  task automatic pulse_redir(input logic [63:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    @(negedge clk);
    redirect_valid = 1'b0;
  endtask

  // Wait for a request, hold ready low for dly cycles checking stability, then accept it.
  task automatic issue(input logic [63:0] exp_addr, input int dly);
    int t = 0;
    while (!mem_req_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("req_seen", 512'(mem_req_valid), 512'(1));
    chk("req_addr", 512'(mem_req_addr), 512'(exp_addr));
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      chk("bp_hold", 512'({mem_req_valid, mem_req_addr}), 512'({1'b1, exp_addr}));
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    chk("single_req", 512'(mem_req_valid), 512'(0));
  endtask

  task automatic respond(input int lat, input logic [511:0] d, input bit exp_line,
                         input logic [3:0] exp_off);
    for (int i = 1; i < lat; i++) @(negedge clk);
    mem_resp_valid = 1'b1;
    mem_resp_data  = d;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    chk("line_valid", 512'(line_valid), 512'(exp_line));
    if (exp_line) begin
      chk("line_data", line_data, d);
      chk("line_offset", 512'(line_offset), 512'(exp_off));
    end
    @(negedge clk);
    chk("line_gap", 512'(line_valid), 512'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int base;
    vt[0] = '{0, 64'h0,                   0, 1, 64'h0000_0000_8000_0040, 4'd0};
    vt[1] = '{0, 64'h0,                   5, 2, 64'h0000_0000_8000_0080, 4'd0};
    vt[2] = '{0, 64'h0,                   0, 4, 64'h0000_0000_8000_00C0, 4'd0};
    vt[3] = '{1, 64'h2008,                0, 3, 64'h0000_0000_0000_2000, 4'd2};
    vt[4] = '{0, 64'h0,                   2, 1, 64'h0000_0000_0000_2040, 4'd0};
    vt[5] = '{1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 2, 64'hFFFF_FFFF_FFFF_FFC0, 4'd15};
    vt[6] = '{0, 64'h0,                   0, 1, 64'h0000_0000_0000_0000, 4'd0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req_valid", 512'(mem_req_valid), 512'(0));
    chk("rst_req_addr", 512'(mem_req_addr), 512'(0));
    chk("rst_line_valid", 512'(line_valid), 512'(0));
    chk("rst_line_data", line_data, 512'(0));
    chk("rst_line_offset", 512'(line_offset), 512'(0));
    chk("rst_busy", 512'(busy), 512'(0));
    rst_n = 1'b1;
    #1 chk("boot_no_early_req", 512'(mem_req_valid), 512'(0));

    // Boot fetch
    issue(64'h8000_0000, 0);
    respond(3, mk(1), 1'b1, 4'd0);
    chk("boot_idle", 512'(busy), 512'(0));

    // Table: sequential fetches, backpressure, redirects from IDLE, address wrap
    for (int i = 0; i < 7; i++) begin
      if (vt[i].redir) pulse_redir(vt[i].rpc);
      else pulse_fetch();
      issue(vt[i].exp_addr, vt[i].dly);
      respond(vt[i].lat, mk(10 + i), 1'b1, vt[i].exp_off);
      repeat (3) @(negedge clk);
      chk("idle_after_line", 512'(busy), 512'(0));
    end

    // Redirect while waiting: old line dropped, restart at target with offset
    pulse_fetch();
    issue(64'h40, 0);
    pulse_redir(64'h1234);
    respond(2, mk(100), 1'b0, 4'd0);
    issue(64'h1200, 0);
    respond(1, mk(101), 1'b1, 4'd13);
    pulse_fetch();
    issue(64'h1240, 0);
    respond(1, mk(102), 1'b1, 4'd0);

    // Redirect in unaccepted REQ with an earlier pending pulse: exactly one line out
    repeat (2) @(negedge clk);
    base = n_lines;
    pulse_fetch();
    pulse_fetch();
    pulse_redir(64'h4444);
    chk("stale_addr_kept", 512'({mem_req_valid, mem_req_addr}), 512'({1'b1, 64'h1280}));
    issue(64'h1280, 1);
    respond(2, mk(110), 1'b0, 4'd0);
    issue(64'h4440, 0);
    respond(1, mk(111), 1'b1, 4'd1);
    repeat (4) @(negedge clk);
    chk("pending_discarded_busy", 512'(busy), 512'(0));
    chk("pending_discarded_lines", 512'(n_lines - base), 512'(1));

    // Simultaneous redirect and response in WAIT
    pulse_fetch();
    issue(64'h4480, 0);
    mem_resp_valid = 1'b1;
    mem_resp_data  = mk(119);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h9000;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    redirect_valid = 1'b0;
    chk("simul_no_line", 512'(line_valid), 512'(0));
    issue(64'h9000, 0);
    respond(3, mk(120), 1'b1, 4'd0);

    // Reset mid-WAIT, then a stray response while in REQ is ignored
    pulse_fetch();
    issue(64'h9040, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 512'(busy), 512'(0));
    chk("midrst_req_valid", 512'(mem_req_valid), 512'(0));
    chk("midrst_line_valid", 512'(line_valid), 512'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mem_resp_valid = 1'b1;
    mem_resp_data  = mk(129);
    @(negedge clk);
    mem_resp_valid = 1'b0;
    chk("stray_resp_ignored", 512'(line_valid), 512'(0));
    issue(64'h8000_0000, 0);
    respond(3, mk(130), 1'b1, 4'd0);

    repeat (3) @(negedge clk);
    chk("no_back2back", 512'(n_back2back), 512'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
